// File: rtl/tog_sync_tx.sv
// rtl/tog_sync_tx.sv - paced launcher feeding a toggle-pulse synchronizer
//
// Buffers upstream words in a small FIFO and launches them one at a time
// toward a toggle synchronizer. Each launch presents a word on tx_data
// together with a one-cycle tx_pulse, then holds for max(gap,1) cycles so
// the far side has time to capture the word before the next one arrives.
//
// Ports:
//   clk      - single clock, rising edge (source domain of the crossing)
//   rst      - synchronous active-high reset
//   en       - launch enable (gates new launches only)
//   gap      - minimum hold after a launch, in clk cycles (sampled at launch)
//   s_valid  - upstream word valid
//   s_ready  - FIFO can accept a word this cycle
//   s_data   - upstream word
//   tx_data  - registered word to the synchronizer data input
//   tx_pulse - registered single-cycle launch strobe
//   busy     - high while holding after a launch
//   level    - FIFO occupancy

module tog_sync_tx #(
  parameter int N     = 8,
  parameter int DEPTH = 4,
  parameter int GAP_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [GAP_W-1:0]           gap,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [N-1:0]               s_data,
  output logic [N-1:0]               tx_data,
  output logic                       tx_pulse,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [GAP_W-1:0]   cnt_q;
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [LVL_W-1:0]   level_q;
  logic [N-1:0]       mem [DEPTH];
  logic               push, launch;
  logic [GAP_W-1:0]   gap_eff;

  // Readiness looks only at the current level, so a pop in the same cycle
  // does not open a slot for a push when full.
  assign s_ready = (level_q < LVL_W'(DEPTH)) && !rst;
  assign push    = s_valid && s_ready;
  assign gap_eff = (gap == '0) ? GAP_W'(1) : gap;
  assign level   = level_q;
  assign busy    = (state_q == HOLD);

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && (level_q != '0)) begin
          launch  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // <= 1 rather than == 1 so a stray zero count cannot wrap into a long hold.
        if (cnt_q <= GAP_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      tx_data  <= '0;
      tx_pulse <= 1'b0;
    end else begin
      tx_pulse <= launch;
      if (launch) begin
        tx_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + AW'(1);
        cnt_q   <= gap_eff;
      end else if (state_q == HOLD) begin
        cnt_q <= cnt_q - GAP_W'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (push && !launch) begin
        level_q <= level_q + LVL_W'(1);
      end else if (!push && launch) begin
        level_q <= level_q - LVL_W'(1);
      end
    end
  end

  // Storage is not reset; occupancy and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

endmodule

// File: tb/tb_tog_sync_tx.sv
// tb/tb_tog_sync_tx.sv - directed bench for tog_sync_tx

module tb_tog_sync_tx;

  localparam int N     = 8;
  localparam int DEPTH = 4;
  localparam int GAP_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [GAP_W-1:0] gap;
  logic             s_valid;
  logic             s_ready;
  logic [N-1:0]     s_data;
  logic [N-1:0]     tx_data;
  logic             tx_pulse;
  logic             busy;
  logic [2:0]       level;

  tog_sync_tx #(.N(N), .DEPTH(DEPTH), .GAP_W(GAP_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .gap     (gap),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .tx_data (tx_data),
    .tx_pulse(tx_pulse),
    .busy    (busy),
    .level   (level)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int max_level;
  int full_block;

  logic [N-1:0] push_q[$];
  int           pulse_cyc[$];
  logic [N-1:0] pulse_dat[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive the queue head, take the edge, then observe 1ns later.
  task automatic step();
    logic acc;
    if (push_q.size() != 0) begin
      s_valid = 1'b1;
      s_data  = push_q[0];
    end else begin
      s_valid = 1'b0;
    end
    acc = s_valid && s_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) void'(push_q.pop_front());
    if (tx_pulse) begin
      pulse_cyc.push_back(cyc);
      pulse_dat.push_back(tx_data);
    end
    if (int'(level) > max_level) max_level = int'(level);
    if (level == 3'd4 && !s_ready) full_block = 1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_rec();
    pulse_cyc.delete();
    pulse_dat.delete();
  endtask

  task automatic wait_pulses(input string tag, input int target, input int bound);
    int k;
    k = 0;
    while (pulse_dat.size() < target && k < bound) begin
      step();
      k++;
    end
    check({tag, "_timeout"}, (pulse_dat.size() >= target), 1);
  endtask

  initial begin
    int base;

    // Reset with s_valid held high: nothing may be pushed.
    rst = 1'b1; en = 1'b1; gap = 8'd3; s_valid = 1'b1; s_data = 8'h77;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_pulse", tx_pulse, 0);
    check("rst_level", level, 0);
    s_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst_s_ready", s_ready, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_level", level, 0);

    // Single word, gap 3.
    max_level = 0; full_block = 0;
    push_q.push_back(8'hA5);
    step();
    check("single_level_after_push", level, 1);
    check("single_no_early_pulse", tx_pulse, 0);
    step();
    check("single_pulse", tx_pulse, 1);
    check("single_data", tx_data, 8'hA5);
    check("single_busy1", busy, 1);
    check("single_level_after_pop", level, 0);
    step();
    check("single_pulse_once", tx_pulse, 0);
    check("single_busy2", busy, 1);
    step();
    check("single_busy3", busy, 1);
    step();
    check("single_idle", busy, 0);
    check("single_data_hold", tx_data, 8'hA5);
    steps(3);
    check("single_data_hold_idle", tx_data, 8'hA5);

    // Burst of six words into a four-deep FIFO, gap 3.
    clear_rec();
    max_level = 0; full_block = 0;
    for (int i = 1; i <= 6; i++) push_q.push_back(N'(i));
    steps(40);
    check("burst_pulses", pulse_dat.size(), 6);
    for (int i = 0; i < 6 && i < pulse_dat.size(); i++)
      check($sformatf("burst_data%0d", i), pulse_dat[i], i + 1);
    for (int i = 1; i < 6 && i < pulse_cyc.size(); i++)
      check($sformatf("burst_space%0d", i), pulse_cyc[i] - pulse_cyc[i-1], 4);
    check("burst_full_blocks", full_block, 1);
    check("burst_max_level", max_level, 4);
    check("burst_drained", level, 0);

    // Gap zero behaves as gap one: launches every 2 cycles.
    en = 1'b0;
    gap = 8'd0;
    for (int i = 0; i < 3; i++) push_q.push_back(8'h21 + N'(i));
    steps(3);
    check("gap0_queued_with_en_low", level, 3);
    clear_rec();
    en = 1'b1;
    steps(10);
    check("gap0_pulses", pulse_dat.size(), 3);
    for (int i = 1; i < 3 && i < pulse_cyc.size(); i++)
      check($sformatf("gap0_space%0d", i), pulse_cyc[i] - pulse_cyc[i-1], 2);
    for (int i = 0; i < 3 && i < pulse_dat.size(); i++)
      check($sformatf("gap0_data%0d", i), pulse_dat[i], 8'h21 + i);

    // Enable dropped during the hold of word 2 of 4.
    en = 1'b0;
    gap = 8'd3;
    for (int i = 0; i < 4; i++) push_q.push_back(8'h41 + N'(i));
    steps(4);
    check("en_queued", level, 4);
    clear_rec();
    en = 1'b1;
    wait_pulses("en_second", 2, 20);
    en = 1'b0;
    gap = 8'd9;
    steps(10);
    check("en_no_more_pulses", pulse_dat.size(), 2);
    check("en_level_held", level, 2);
    check("en_hold_done", busy, 0);
    check("en_data_held", tx_data, 8'h42);
    en = 1'b1;
    gap = 8'd3;
    step();
    check("en_resume_pulse", tx_pulse, 1);
    check("en_resume_data", tx_data, 8'h43);
    check("en_resume_level", level, 1);
    steps(12);
    check("en_drained", level, 0);

    // Reset during the first hold discards the queue.
    en = 1'b0;
    for (int i = 0; i < 3; i++) push_q.push_back(8'h51 + N'(i));
    steps(3);
    check("rsthold_queued", level, 3);
    clear_rec();
    en = 1'b1;
    wait_pulses("rsthold_first", 1, 5);
    check("rsthold_in_hold", busy, 1);
    rst = 1'b1;
    step();
    check("rsthold_no_pulse", tx_pulse, 0);
    check("rsthold_level", level, 0);
    check("rsthold_busy", busy, 0);
    check("rsthold_tx_data", tx_data, 0);
    rst = 1'b0;
    #1;
    check("rsthold_ready", s_ready, 1);
    base = pulse_dat.size();
    steps(12);
    check("rsthold_silent", pulse_dat.size(), base);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tog_sync_tx.md
TOG_SYNC_TX -- requirements
Module: tog_sync_tx

Interface
REQ-001 The block SHALL have parameter N, default 8: data word width, matching the downstream toggle synchronizer.
REQ-002 The block SHALL have parameter DEPTH, default 4: FIFO depth in words (power of 2, >= 2).
REQ-003 The block SHALL have parameter GAP_W, default 8: width of the gap input.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock (source domain of the crossing); all logic SHALL be clocked on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit: launch enable.
REQ-007 The block SHALL have port gap, input, GAP_W bits: minimum launch-to-next-launch hold in clk cycles.
REQ-008 The block SHALL have port s_valid, input, 1 bit: upstream word valid.
REQ-009 The block SHALL have port s_ready, output, 1 bit: block can accept a word.
REQ-010 The block SHALL have port s_data, input, N bits: upstream word.
REQ-011 The block SHALL have port tx_data, output, N bits, registered: word presented to the synchronizer data input.
REQ-012 The block SHALL have port tx_pulse, output, 1 bit, registered: single-cycle launch strobe to the synchronizer pulse input.
REQ-013 The block SHALL have port busy, output, 1 bit: high while in HOLD.
REQ-014 The block SHALL have port level, output, clog2(DEPTH)+1 bits: FIFO occupancy.

Function
REQ-015 The block SHALL hold words in a first-in first-out buffer of DEPTH entries; a push SHALL occur on a clk edge where s_valid and s_ready are both high.
REQ-016 s_ready SHALL be combinational and equal (level < DEPTH) and not rst; when full, s_ready SHALL be 0 even if a pop occurs in the same cycle.
REQ-017 On a cycle with both a push and a pop, level SHALL stay unchanged and word order SHALL be preserved.
REQ-018 The state machine SHALL have exactly two states, IDLE and HOLD.
REQ-019 In IDLE with level > 0 and en = 1 (a launch), on the edge the block SHALL: pop the head into tx_data; set tx_pulse to 1; load the hold counter with G = max(gap, 1); and go to HOLD.
REQ-020 tx_pulse SHALL be high for exactly one cycle per launch, which is the first HOLD cycle.
REQ-021 In HOLD, the hold counter SHALL decrement each cycle; in a HOLD cycle where the counter equals 1, the next state SHALL be IDLE.
REQ-022 Launch-to-launch spacing SHALL be exactly G+1 cycles while words remain queued and en = 1.
REQ-023 tx_data SHALL change only on a launch edge and SHALL otherwise hold its value, including in IDLE.
REQ-024 gap SHALL be sampled only at launch; changes to gap during HOLD SHALL not affect the current hold.
REQ-025 en = 0 SHALL block new launches only; an in-progress HOLD SHALL run to completion, and pushes SHALL still be accepted.
REQ-026 Latency: a push into an empty FIFO on edge k with the block in IDLE and en = 1 SHALL produce tx_pulse high in the cycle after edge k+1.
REQ-027 busy SHALL equal (state == HOLD).
REQ-028 Pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or drop below 0.

Reset
REQ-029 While rst = 1 on an edge, the block SHALL set state to IDLE, hold counter to 0, FIFO pointers and level to 0, tx_data to 0 and tx_pulse to 0; FIFO storage contents need not be cleared.
REQ-030 A reset asserted mid-HOLD SHALL abandon the hold; queued words SHALL be discarded; and no tx_pulse SHALL occur in the cycle after the reset edge.
REQ-031 In the first cycle after rst deasserts, s_ready SHALL be 1 and busy SHALL be 0.

Verification
REQ-032 Reset: hold rst for 2 cycles with s_valid = 1 -> no push; tx_data = 0, tx_pulse = 0, level = 0, s_ready = 0 during reset, then 1 after.
REQ-033 Single word: gap = 3, push 0xA5 at edge k -> tx_pulse high in the single cycle after edge k+1, tx_data = 0xA5, busy high for 3 cycles, then IDLE.
REQ-034 Burst/full: gap = 3, push 6 words 0x01..0x06 back-to-back -> s_ready drops when level = 4, pulses every 4 cycles, tx_data sequence 0x01..0x06 in order, no word lost.
REQ-035 Gap zero: gap = 0 with 3 words queued -> pulses spaced every 2 cycles (gap treated as 1).
REQ-036 Enable: deassert en during HOLD of word 2 of 4 -> HOLD completes, no further pulse, level stays 2; reassert en -> next pulse in the following cycle.
REQ-037 Reset mid-HOLD: 3 words queued, assert rst during the first HOLD -> level = 0, busy = 0, tx_data = 0, no pulses afterwards until new pushes.
